// File: rtl/ddr_burst_seq.sv
// ddr_burst_seq
// Runs one multi-beat DDR burst per descriptor between the accelerator FIFOs
// and the MIG user interface (clk_200 domain).
//
// Ports:
//   clk_200, rst            clock, synchronous active-high reset
//   cmd_empty/cmd_wen/cmd_addr/cmd_len, cmd_rd_en
//                           descriptor FIFO (FWFT) and its pop
//   wd_empty, wd_rd_en      write-data FIFO (FWFT) and its pop
//   rd_fifo_almost_full, rd_fifo_wr_en
//                           read-return FIFO backpressure and push
//   app_rdy, app_wdf_rdy, app_rd_data_valid
//                           MIG handshakes in
//   app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end
//                           MIG command / write-data strobes out
//   busy, done              burst in progress, one-cycle completion pulse
//   err_unexp_rd            sticky: read data returned with nothing in flight
`default_nettype none

module ddr_burst_seq #(
  parameter int ADDR_W    = 28,
  parameter int LEN_W     = 8,
  parameter int ADDR_STEP = 8,
  parameter int MAX_OUT   = 4
) (
  input  logic              clk_200,
  input  logic              rst,
  input  logic              cmd_empty,
  input  logic              cmd_wen,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              cmd_rd_en,
  input  logic              wd_empty,
  output logic              wd_rd_en,
  input  logic              rd_fifo_almost_full,
  output logic              rd_fifo_wr_en,
  input  logic              app_rdy,
  input  logic              app_wdf_rdy,
  input  logic              app_rd_data_valid,
  output logic              app_en,
  output logic [2:0]        app_cmd,
  output logic [ADDR_W-1:0] app_addr,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  output logic              busy,
  output logic              done,
  output logic              err_unexp_rd
);

  // One extra bit so the in-flight count can actually hold MAX_OUT.
  localparam int OUT_W = $clog2(MAX_OUT) + 1;
  localparam logic [OUT_W-1:0]  MAX_OUT_C = OUT_W'(MAX_OUT);
  localparam logic [ADDR_W-1:0] STEP_C    = ADDR_W'(ADDR_STEP);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR       = 3'd1,
    S_RD_ISSUE = 3'd2,
    S_RD_DRAIN = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [LEN_W-1:0]  cnt_r, cnt_s;
  logic              cmd_done_r, cmd_done_s;
  logic              data_done_r, data_done_s;
  logic [OUT_W-1:0]  out_r, out_s;
  logic              err_r, err_s;
  logic              issue_s;
  logic              cmd_acc_s;
  logic              data_acc_s;
  logic              ret_ok_s;

  // Next-state, datapath updates and combinational handshake outputs.
  always_comb begin
    state_s      = state_r;
    addr_s       = addr_r;
    cnt_s        = cnt_r;
    cmd_done_s   = cmd_done_r;
    data_done_s  = data_done_r;
    cmd_rd_en    = 1'b0;
    wd_rd_en     = 1'b0;
    app_en       = 1'b0;
    app_cmd      = 3'b000;
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
    issue_s      = 1'b0;
    cmd_acc_s    = 1'b0;
    data_acc_s   = 1'b0;

    case (state_r)
      S_IDLE: begin
        cmd_rd_en = !cmd_empty;
        if (!cmd_empty) begin
          addr_s      = cmd_addr;
          cnt_s       = cmd_len;
          cmd_done_s  = 1'b0;
          data_done_s = 1'b0;
          if (cmd_wen) begin
            state_s = S_WR;
          end else begin
            state_s = S_RD_ISSUE;
          end
        end else begin
          state_s = S_IDLE;
        end
      end

      S_WR: begin
        // Command and data halves of a beat complete independently; the
        // flags stop either side from being presented twice.
        app_en       = !cmd_done_r;
        app_cmd      = 3'b000;
        app_wdf_wren = !wd_empty && !data_done_r;
        app_wdf_end  = !wd_empty && !data_done_r;
        cmd_acc_s    = !cmd_done_r && app_rdy;
        data_acc_s   = !wd_empty && !data_done_r && app_wdf_rdy;
        wd_rd_en     = data_acc_s;
        if ((cmd_done_r || cmd_acc_s) && (data_done_r || data_acc_s)) begin
          cmd_done_s  = 1'b0;
          data_done_s = 1'b0;
          addr_s      = addr_r + STEP_C;
          cnt_s       = cnt_r - {{(LEN_W-1){1'b0}}, 1'b1};
          if (cnt_r == {LEN_W{1'b0}}) begin
            state_s = S_DONE;
          end else begin
            state_s = S_WR;
          end
        end else begin
          cmd_done_s  = cmd_done_r || cmd_acc_s;
          data_done_s = data_done_r || data_acc_s;
        end
      end

      S_RD_ISSUE: begin
        app_cmd = 3'b001;
        app_en  = (out_r < MAX_OUT_C) && !rd_fifo_almost_full;
        issue_s = (out_r < MAX_OUT_C) && !rd_fifo_almost_full && app_rdy;
        if (issue_s) begin
          addr_s = addr_r + STEP_C;
          if (cnt_r == {LEN_W{1'b0}}) begin
            state_s = S_RD_DRAIN;
          end else begin
            cnt_s   = cnt_r - {{(LEN_W-1){1'b0}}, 1'b1};
            state_s = S_RD_ISSUE;
          end
        end else begin
          state_s = S_RD_ISSUE;
        end
      end

      S_RD_DRAIN: begin
        if (out_r == {OUT_W{1'b0}}) begin
          state_s = S_DONE;
        end else begin
          state_s = S_RD_DRAIN;
        end
      end

      S_DONE: begin
        state_s = S_IDLE;
      end

      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // In-flight read credit count and unexpected-return detection.
  always_comb begin
    ret_ok_s = app_rd_data_valid && (out_r != {OUT_W{1'b0}});
    out_s    = out_r;
    if (app_rd_data_valid && (out_r == {OUT_W{1'b0}})) begin
      err_s = 1'b1;
    end else begin
      err_s = err_r;
    end
    case ({issue_s, ret_ok_s})
      2'b10:   out_s = out_r + {{(OUT_W-1){1'b0}}, 1'b1};
      2'b01:   out_s = out_r - {{(OUT_W-1){1'b0}}, 1'b1};
      default: out_s = out_r;
    endcase
  end

  // State and datapath registers; reset drops any reads still in flight.
  always_ff @(posedge clk_200) begin
    if (rst) begin
      state_r     <= S_IDLE;
      addr_r      <= {ADDR_W{1'b0}};
      cnt_r       <= {LEN_W{1'b0}};
      cmd_done_r  <= 1'b0;
      data_done_r <= 1'b0;
      out_r       <= {OUT_W{1'b0}};
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      addr_r      <= addr_s;
      cnt_r       <= cnt_s;
      cmd_done_r  <= cmd_done_s;
      data_done_r <= data_done_s;
      out_r       <= out_s;
      err_r       <= err_s;
    end
  end

  assign app_addr      = addr_r;
  assign busy          = (state_r != S_IDLE);
  assign done          = (state_r == S_DONE);
  assign err_unexp_rd  = err_r;
  // Returns are always pushed; the FIFO margin covers every in-flight read.
  assign rd_fifo_wr_en = app_rd_data_valid;

endmodule

`default_nettype wire

// File: tb/tb_ddr_burst_seq.sv
module tb_ddr_burst_seq;

  localparam int ADDR_W    = 28;
  localparam int LEN_W     = 8;
  localparam int ADDR_STEP = 8;
  localparam int MAX_OUT   = 4;
  localparam int RET_DLY   = 10;
  localparam int BUDGET    = 400;

  logic              clk_200 = 1'b0;
  logic              rst;
  logic              cmd_empty;
  logic              cmd_wen;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              cmd_rd_en;
  logic              wd_empty;
  logic              wd_rd_en;
  logic              rd_fifo_almost_full;
  logic              rd_fifo_wr_en;
  logic              app_rdy;
  logic              app_wdf_rdy;
  logic              app_rd_data_valid;
  logic              app_en;
  logic [2:0]        app_cmd;
  logic [ADDR_W-1:0] app_addr;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic              busy;
  logic              done;
  logic              err_unexp_rd;

  always #5 clk_200 = ~clk_200;

  ddr_burst_seq #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .ADDR_STEP(ADDR_STEP), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk_200(clk_200), .rst(rst),
    .cmd_empty(cmd_empty), .cmd_wen(cmd_wen), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_rd_en(cmd_rd_en),
    .wd_empty(wd_empty), .wd_rd_en(wd_rd_en),
    .rd_fifo_almost_full(rd_fifo_almost_full), .rd_fifo_wr_en(rd_fifo_wr_en),
    .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data_valid(app_rd_data_valid),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .busy(busy), .done(done), .err_unexp_rd(err_unexp_rd)
  );

  typedef struct {
    logic              wen;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } desc_t;

  // One burst scenario with its hand-computed outcome.
  typedef struct {
    logic              wen;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    bit                rdy_dly;      // app_rdy lags app_wdf_rdy by 2 cycles
    int                af_lo;        // almost_full window, cycles after pop
    int                af_hi;
    int                exp_done_bc;  // cycle of done, relative to pop cycle
    int                exp_max_out;  // peak reads in flight
    int                exp_at10;     // issues seen by cycle 10 (-1: skip)
    int                exp_push_af;  // returns pushed inside window (-1: skip)
  } vec_t;

  int n_vec  = 0;
  int n_fail = 0;

  // Bench-side environment and observation state
  int                cyc = 0;
  desc_t             desc_q[$];
  int                pop_cyc;
  int                pop_log[$];
  int                ret_q[$];
  bit                ret_en;
  bit                man_valid;
  bit                rdy_dly;
  int                wait_cnt;
  int                af_lo, af_hi;
  logic [ADDR_W-1:0] addr_log[$];
  logic [2:0]        cmdc_log[$];
  int n_wd, n_push, n_push_af, n_done, done_cyc, outst, max_out;
  int af_viol, at10, dbl_pop;
  logic busy_at1;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive();
    int bc;
    bc = cyc - pop_cyc;
    if (desc_q.size() > 0) begin
      cmd_empty = 1'b0;
      cmd_wen   = desc_q[0].wen;
      cmd_addr  = desc_q[0].addr;
      cmd_len   = desc_q[0].len;
    end else begin
      cmd_empty = 1'b1;
      cmd_wen   = ~cmd_wen;   // wiggle direction mid-burst; must be ignored
    end
    app_rdy             = rdy_dly ? (wait_cnt >= 2) : 1'b1;
    app_wdf_rdy         = 1'b1;
    wd_empty            = 1'b0;
    rd_fifo_almost_full = (bc >= af_lo) && (bc < af_hi);
    app_rd_data_valid   = man_valid;
    if (ret_en && ret_q.size() > 0) begin
      if (ret_q[0] <= cyc) begin
        app_rd_data_valid = 1'b1;
        void'(ret_q.pop_front());
      end
    end
  endtask

  task automatic monitor();
    int bc;
    bc = cyc - pop_cyc;
    if (bc == 1)  busy_at1 = busy;
    if (bc == 10) at10 = addr_log.size();
    if (cmd_rd_en) begin
      if (done) dbl_pop++;
      pop_cyc = cyc;
      pop_log.push_back(cyc);
      if (desc_q.size() > 0) void'(desc_q.pop_front());
    end
    if (app_en && app_rdy) begin
      addr_log.push_back(app_addr);
      cmdc_log.push_back(app_cmd);
      if (app_cmd == 3'b001) begin
        ret_q.push_back(cyc + RET_DLY);
        outst++;
      end
      wait_cnt = 0;
    end else if (app_en) begin
      wait_cnt++;
    end else begin
      wait_cnt = 0;
    end
    if (rd_fifo_wr_en) begin
      n_push++;
      if (outst > 0) outst--;
      if (rd_fifo_almost_full) n_push_af++;
    end
    if (outst > max_out) max_out = outst;
    if (wd_rd_en) n_wd++;
    if (rd_fifo_almost_full && app_en) af_viol++;
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled mid-cycle.
  task automatic tick();
    @(posedge clk_200);
    cyc++;
    #1;
    drive();
    @(negedge clk_200);
    monitor();
  endtask

  task automatic clear_logs();
    pop_cyc = 1 << 30;
    pop_log.delete();
    addr_log.delete();
    cmdc_log.delete();
    n_wd = 0; n_push = 0; n_push_af = 0; n_done = 0; done_cyc = 0;
    outst = 0; max_out = 0; af_viol = 0; at10 = -1; dbl_pop = 0;
    busy_at1 = 1'b0; wait_cnt = 0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int                beats;
    logic [ADDR_W-1:0] ea;
    string             tag;
    clear_logs();
    rdy_dly = v.rdy_dly;
    af_lo   = v.af_lo;
    af_hi   = v.af_hi;
    ret_en  = 1'b1;
    beats   = int'(v.len) + 1;
    tag     = $sformatf("v%0d", idx);
    desc_q.push_back('{v.wen, v.addr, v.len});
    for (int i = 0; i < BUDGET && n_done == 0; i++) tick();
    check({tag, "_done_cnt"}, n_done, 1);
    check({tag, "_done_cyc"}, done_cyc - pop_cyc, v.exp_done_bc);
    tick();
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_busy_at1"}, busy_at1, 1);
    check({tag, "_n_cmds"}, addr_log.size(), beats);
    for (int i = 0; i < beats; i++) begin
      if (i < addr_log.size()) begin
        ea = v.addr + ADDR_W'(i * ADDR_STEP);
        check($sformatf("%s_addr%0d", tag, i), addr_log[i], ea);
        check($sformatf("%s_cmd%0d", tag, i), cmdc_log[i], v.wen ? 0 : 1);
      end
    end
    check({tag, "_wd_pops"}, n_wd, v.wen ? beats : 0);
    check({tag, "_rd_push"}, n_push, v.wen ? 0 : beats);
    check({tag, "_max_out"}, max_out, v.exp_max_out);
    check({tag, "_af_gate"}, af_viol, 0);
    check({tag, "_err"}, err_unexp_rd, 0);
    check({tag, "_pop_in_done"}, dbl_pop, 0);
    if (v.exp_at10 >= 0)    check({tag, "_issued_by10"}, at10, v.exp_at10);
    if (v.exp_push_af >= 0) check({tag, "_push_in_af"}, n_push_af, v.exp_push_af);
    af_lo = 0;
    af_hi = 0;
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{1'b1, 28'h0000100, 8'd3,   1'b0, 0,  0,  5,   0, -1, -1};
    vecs[1] = '{1'b1, 28'h0000200, 8'd3,   1'b1, 0,  0,  13,  0, -1, -1};
    vecs[2] = '{1'b0, 28'h0001000, 8'd7,   1'b0, 0,  0,  27,  4,  4, -1};
    vecs[3] = '{1'b0, 28'h0002000, 8'd7,   1'b0, 11, 16, 31,  4,  4,  4};
    vecs[4] = '{1'b1, 28'hFFFFFF8, 8'd1,   1'b0, 0,  0,  3,   0, -1, -1};
    vecs[5] = '{1'b0, 28'h0000040, 8'd0,   1'b0, 0,  0,  13,  1, -1, -1};
    vecs[6] = '{1'b1, 28'h0000000, 8'd255, 1'b0, 0,  0,  257, 0, -1, -1};

    rst = 1'b1;
    cmd_wen = 1'b0;
    ret_en = 1'b0;
    man_valid = 1'b0;
    rdy_dly = 1'b0;
    af_lo = 0;
    af_hi = 0;
    clear_logs();
    drive();

    // Reset state
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_app_en", app_en, 0);
    check("rst_cmd_rd_en", cmd_rd_en, 0);
    rst = 1'b0;
    tick();
    check("idle_app_addr", app_addr, 0);
    check("idle_err", err_unexp_rd, 0);
    check("idle_wdf_wren", app_wdf_wren, 0);
    check("idle_wd_rd_en", wd_rd_en, 0);

    foreach (vecs[k]) run_vec(vecs[k], k);

    // Back-to-back descriptors: second pop waits for the cycle after DONE.
    clear_logs();
    rdy_dly = 1'b0;
    ret_en  = 1'b1;
    desc_q.push_back('{1'b1, 28'h0000300, 8'd0});
    desc_q.push_back('{1'b1, 28'h0000400, 8'd0});
    for (int i = 0; i < BUDGET && n_done < 2; i++) tick();
    check("b2b_done_cnt", n_done, 2);
    check("b2b_pops", pop_log.size(), 2);
    if (pop_log.size() == 2) check("b2b_pop_gap", pop_log[1] - pop_log[0], 3);
    check("b2b_pop_in_done", dbl_pop, 0);
    if (addr_log.size() == 2) begin
      check("b2b_addr0", addr_log[0], 28'h0000300);
      check("b2b_addr1", addr_log[1], 28'h0000400);
    end else begin
      check("b2b_n_cmds", addr_log.size(), 2);
    end
    tick();

    // Reset in RD_DRAIN with two reads in flight, then two late returns.
    clear_logs();
    ret_en = 1'b1;
    desc_q.push_back('{1'b0, 28'h0003000, 8'd7});
    for (int i = 0; i < BUDGET && !(addr_log.size() == 8 && outst == 2); i++) tick();
    check("rstd_setup_out", outst, 2);
    check("rstd_setup_issues", addr_log.size(), 8);
    ret_en = 1'b0;
    ret_q.delete();
    tick();
    check("rstd_busy_pre", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstd_busy", busy, 0);
    check("rstd_err_pre", err_unexp_rd, 0);
    n_push = 0;
    man_valid = 1'b1;
    tick();
    man_valid = 1'b0;
    tick();
    check("rstd_err_1st", err_unexp_rd, 1);
    man_valid = 1'b1;
    tick();
    man_valid = 1'b0;
    tick();
    tick();
    check("rstd_err_sticky", err_unexp_rd, 1);
    check("rstd_pushes", n_push, 2);
    check("rstd_no_done", n_done, 0);
    check("rstd_idle", busy, 0);
    check("rstd_app_en", app_en, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
